// File: rtl/c1541_gcr_write_if.sv
// Handshake and track-RAM bus between the 1541 VIA logic, the bit-cell timer and
// the GCR write serializer.
interface c1541_gcr_write_if #(
    parameter int unsigned ADDR_W = 13
);
    localparam int unsigned BIT_W = ADDR_W + 3;

    logic              mode;
    logic              wps_n;
    logic              soe;
    logic              bit_tick;
    logic [BIT_W-1:0]  bit_addr;
    logic [7:0]        din;
    logic              ram_ready;
    logic [7:0]        ram_do;
    logic              byte_n;
    logic              busy;
    logic [ADDR_W-1:0] byte_addr;
    logic [7:0]        ram_di;
    logic              ram_we;

    modport master (
        output mode, wps_n, soe, bit_tick, bit_addr, din, ram_ready, ram_do,
        input  byte_n, busy, byte_addr, ram_di, ram_we
    );

    modport slave (
        input  mode, wps_n, soe, bit_tick, bit_addr, din, ram_ready, ram_do,
        output byte_n, busy, byte_addr, ram_di, ram_we
    );
endinterface

// File: rtl/c1541_gcr_write.sv
// 1541 GCR write serializer: shifts VIA bytes out MSB-first, one bit per bit cell,
// and merges each bit into the byte-wide track buffer via read-modify-write.
module c1541_gcr_write #(
    parameter int unsigned ADDR_W = 13
) (
    input  logic             clk32,
    input  logic             reset_n,
    c1541_gcr_write_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_FLUSH} state_t;

    state_t            r_state, w_state_nxt;
    logic [2:0]        r_bit_count, w_bit_count_nxt;
    logic [7:0]        r_shreg, w_shreg_nxt;
    logic [7:0]        r_mbuf, w_mbuf_nxt;
    logic [ADDR_W-1:0] r_maddr, w_maddr_nxt;
    logic              r_mvalid, w_mvalid_nxt;
    logic              r_byte_n, w_byte_n_nxt;
    logic              r_busy, w_busy_nxt;
    logic              r_ram_we, w_ram_we_nxt;
    logic [7:0]        r_ram_di, w_ram_di_nxt;
    logic [ADDR_W-1:0] r_byte_addr, w_byte_addr_nxt;

    logic              w_wr_act;
    logic              w_bit;
    logic [2:0]        w_pos;
    logic [ADDR_W-1:0] w_a;
    logic [7:0]        w_base;
    logic [7:0]        w_mask;
    logic [7:0]        w_merged;

    // Bit merge: a new byte address starts from RAM contents, otherwise keep accumulating.
    always_comb begin
        w_wr_act = ~bus.mode & bus.wps_n & bus.ram_ready;
        w_pos    = bus.bit_addr[2:0];
        w_a      = bus.bit_addr[ADDR_W+2:3];
        w_bit    = (r_bit_count == 3'd0) ? bus.din[7] : r_shreg[7];
        w_base   = (!r_mvalid || (w_a != r_maddr)) ? bus.ram_do : r_mbuf;
        w_mask   = 8'h80 >> w_pos;
        w_merged = w_bit ? (w_base | w_mask) : (w_base & ~w_mask);
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_bit_count_nxt = r_bit_count;
        w_shreg_nxt     = r_shreg;
        w_mbuf_nxt      = r_mbuf;
        w_maddr_nxt     = r_maddr;
        w_mvalid_nxt    = r_mvalid;
        w_byte_n_nxt    = 1'b1;
        w_ram_we_nxt    = 1'b0;
        w_ram_di_nxt    = r_ram_di;
        w_byte_addr_nxt = w_a;

        case (r_state)
            S_IDLE: begin
                if (w_wr_act) begin
                    w_state_nxt     = S_SHIFT;
                    w_bit_count_nxt = 3'd0;
                    w_mvalid_nxt    = 1'b0;
                end
            end
            S_SHIFT: begin
                w_byte_n_nxt = r_byte_n;
                if (!w_wr_act) begin
                    // A tick coinciding with the abort is dropped; only merged bits are flushed.
                    w_byte_n_nxt = 1'b1;
                    if (r_mvalid) begin
                        w_state_nxt     = S_FLUSH;
                        w_ram_we_nxt    = 1'b1;
                        w_ram_di_nxt    = r_mbuf;
                        w_byte_addr_nxt = r_maddr;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end else if (bus.bit_tick) begin
                    w_shreg_nxt     = (r_bit_count == 3'd0) ? {bus.din[6:0], 1'b0}
                                                            : {r_shreg[6:0], 1'b0};
                    w_bit_count_nxt = r_bit_count + 3'd1;
                    w_mbuf_nxt      = w_merged;
                    w_maddr_nxt     = w_a;
                    w_mvalid_nxt    = 1'b1;
                    w_byte_n_nxt    = ~((r_bit_count == 3'd7) & bus.soe);
                    if (w_pos == 3'd7) begin
                        w_ram_we_nxt = 1'b1;
                        w_ram_di_nxt = w_merged;
                        w_mvalid_nxt = 1'b0;
                    end
                end
            end
            S_FLUSH: begin
                w_state_nxt  = S_IDLE;
                w_mvalid_nxt = 1'b0;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        w_busy_nxt = (w_state_nxt != S_IDLE);
    end

    always_ff @(posedge clk32 or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_bit_count <= 3'd0;
            r_shreg     <= 8'd0;
            r_mbuf      <= 8'd0;
            r_maddr     <= '0;
            r_mvalid    <= 1'b0;
            r_byte_n    <= 1'b1;
            r_busy      <= 1'b0;
            r_ram_we    <= 1'b0;
            r_ram_di    <= 8'd0;
            r_byte_addr <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_bit_count <= w_bit_count_nxt;
            r_shreg     <= w_shreg_nxt;
            r_mbuf      <= w_mbuf_nxt;
            r_maddr     <= w_maddr_nxt;
            r_mvalid    <= w_mvalid_nxt;
            r_byte_n    <= w_byte_n_nxt;
            r_busy      <= w_busy_nxt;
            r_ram_we    <= w_ram_we_nxt;
            r_ram_di    <= w_ram_di_nxt;
            r_byte_addr <= w_byte_addr_nxt;
        end
    end

    assign bus.byte_n    = r_byte_n;
    assign bus.busy      = r_busy;
    assign bus.ram_we    = r_ram_we;
    assign bus.ram_di    = r_ram_di;
    assign bus.byte_addr = r_byte_addr;
endmodule

// File: doc/c1541_gcr_write.md
Name: c1541_gcr_write

Overview:
Write-side GCR serializer for the 1541 drive model. In write mode it takes parallel GCR bytes from the 1541 logic (VIA port), shifts them out MSB-first one bit per bit cell, and merges each bit into the byte-wide track buffer RAM at the current bit position using read-modify-write. It generates byte-ready to request the next byte. It shares bit-cell timing (bit_tick, bit_addr) with the read path and owns the RAM write port.

Parameters:
ADDR_W, 13, track buffer byte address width (bit address is ADDR_W+3 bits)

Ports:
clk32      in   1   system clock, 32 MHz
reset_n    in   1   asynchronous active-low reset
mode       in   1   1 = read, 0 = write
wps_n      in   1   write-protect sense, 0 = protected
soe        in   1   serial output (byte-ready) enable
bit_tick   in   1   one-cycle strobe per bit cell; ticks are at least 64 cycles apart
bit_addr   in   16  current bit position on track; stable at least 2 cycles before bit_tick, advances after it
din        in   8   GCR byte from 1541 logic
ram_ready  in   1   track buffer valid; 0 aborts writing
ram_do     in   8   track RAM read data for byte_addr, 1-cycle read latency
byte_n     out  1   byte ready, active low
busy       out  1   high in SHIFT or FLUSH
byte_addr  out  13  track RAM byte address
ram_di     out  8   track RAM write data
ram_we     out  1   track RAM write enable, one-cycle pulse

Behaviour:
- Reset state: IDLE; byte_n=1, busy=0, ram_we=0, ram_di=0, byte_addr=0, bit_count=0, mvalid=0.
- wr_act = ~mode & wps_n & ram_ready.
- byte_addr is registered. It follows bit_addr[15:3] every cycle, except during FLUSH, when it holds maddr.
- IDLE:
  - ram_we=0, byte_n=1.
  - When wr_act=1: go to SHIFT with bit_count=0 and mvalid=0.
- SHIFT, on bit_tick with wr_act=1:
  - Output bit: if bit_count==0, bit = din[7] and shreg <= {din[6:0],0}; otherwise bit = shreg[7] and shreg shifts left.
  - bit_count increments modulo 8.
  - Merge: let p = bit_addr[2:0] and a = bit_addr[15:3].
    - If mvalid=0 or a != maddr: base = ram_do. Otherwise base = mbuf.
    - Write the bit into base bit (7-p). Result goes to mbuf; maddr <= a; mvalid <= 1.
  - If p==7: the next cycle drives ram_we=1, ram_di=merged byte, byte_addr=a, then sets mvalid=0.
  - Byte ready: on the tick where bit_count==7 and soe=1, byte_n goes 0. It returns to 1 on the next bit_tick or on leaving SHIFT.
- SHIFT, when wr_act falls (including in the same cycle as a bit_tick; that tick's bit is discarded):
  - If mvalid=1: go to FLUSH.
  - Otherwise: go to IDLE.
- FLUSH: one cycle with ram_we=1, ram_di=mbuf, byte_addr=maddr; then IDLE, mvalid=0. A later re-entry to SHIFT restarts bit_count at 0.
- Wrap-around: bit_addr wrapping to 0 needs no special case. An address change simply starts a new merge byte. Standard track lengths are whole bytes.
- An unaligned start or stop preserves the RAM bits not covered by the write, because of the merge from ram_do.
- Reset asserted mid-operation: immediate return to reset values. A pending partial byte is discarded; no flush.
- Read mode never drives ram_we.

Test Plan:
- Aligned write: bit_addr from 0, din=0x55 for 8 ticks -> next cycle after tick 8: ram_we=1, ram_di=0x55, byte_addr=0. byte_n=0 from tick 8 until tick 9 (soe=1).
- Unaligned start at bit_addr=3, ram_do=0xFF, din=0x00 -> first write byte_addr=0, ram_di=0xE0. After 3 more ticks, mode=1 -> FLUSH writes byte_addr=1, ram_di=0x1F.
- Abort mid-byte: start at bit_addr=16, ram_do=0x00, din=0xFF, 3 ticks, then mode=1 -> single FLUSH: byte_addr=2, ram_di=0xE0; then IDLE, busy=0, no further ram_we.
- Protection/gating: wps_n=0 with mode=0 -> no ram_we, byte_n=1. wps_n=1, soe=0 -> RAM writes occur but byte_n stays 1.
- Wrap: bit_addr 49992..49999 then 0..7, din=0xA5 -> writes byte_addr=6249, ram_di=0xA5, then byte_addr=0, ram_di=0xA5.
- Reset mid-byte: after 4 ticks, reset_n=0 -> ram_we=0 and byte_n=1 immediately, busy=0, no write after release until a new byte completes.
